otbn_rf_gen_ff: RTL and testbench

Parametrised flop-based register file for OTBN, generalising the 39b base GPR file to configurable width, depth, read-port count and number of hard-wired entries. It adds a sequential secure-wipe engine that overwrites every writable entry, one per cycle, with caller-supplied data. It also keeps a registered spurious-write-enable detector. It sits under the integrity-wrapping register-file module; integrity generation and checking stay in that wrapper.

---
 rtl/otbn_rf_gen_ff_pkg.sv | 16 +
 rtl/otbn_rf_gen_ff_if.sv | 31 +++
 rtl/otbn_rf_gen_ff_wipe_ctrl.sv | 73 +++++++
 rtl/otbn_rf_gen_ff.sv | 138 +++++++++++++
 tb/tb_otbn_rf_gen_ff.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/otbn_rf_gen_ff_pkg.sv
// Shared types and defaults for the generic flop-based OTBN register file.
//   NGpr          : default number of entries
//   BaseIntgWidth : default entry width (32b data + 7b integrity)
//   otbn_rf_wipe_e: secure-wipe FSM states, sparse-encoded (pairwise Hamming distance >= 3)
package otbn_rf_gen_ff_pkg;

    localparam int unsigned NGpr          = 32;
    localparam int unsigned BaseIntgWidth = 39;

    typedef enum logic [4:0] {
        StIdle = 5'b01011,
        StWipe = 5'b10101,
        StDone = 5'b11110
    } otbn_rf_wipe_e;

endpackage

// File: rtl/otbn_rf_gen_ff_if.sv
// Bus bundle for otbn_rf_gen_ff: write port, read ports and secure-wipe control.
//   master: the register-file user (drives writes, read addresses, wipe requests)
//   slave : the register file itself (returns read data, wipe status, fault flag)
interface otbn_rf_gen_ff_if
    import otbn_rf_gen_ff_pkg::*;
#(
    parameter int unsigned Width      = BaseIntgWidth,
    parameter int unsigned AddrW      = 5,
    parameter int unsigned NumRdPorts = 2
);
    logic                                 wr_en_i;
    logic [AddrW-1:0]                     wr_addr_i;
    logic [Width-1:0]                     wr_data_i;
    logic [NumRdPorts-1:0][AddrW-1:0]     rd_addr_i;
    logic [NumRdPorts-1:0][Width-1:0]     rd_data_o;
    logic                                 wipe_req_i;
    logic [Width-1:0]                     wipe_data_i;
    logic                                 wipe_busy_o;
    logic                                 wipe_done_o;
    logic                                 we_err_o;

    modport master (
        output wr_en_i, wr_addr_i, wr_data_i, rd_addr_i, wipe_req_i, wipe_data_i,
        input  rd_data_o, wipe_busy_o, wipe_done_o, we_err_o
    );

    modport slave (
        input  wr_en_i, wr_addr_i, wr_data_i, rd_addr_i, wipe_req_i, wipe_data_i,
        output rd_data_o, wipe_busy_o, wipe_done_o, we_err_o
    );
endinterface

// File: rtl/otbn_rf_gen_ff_wipe_ctrl.sv
// Secure-wipe sequencer: walks every writable entry once, one per cycle.
//   clk_i, rst_ni : clock, async active-low reset
//   wipe_req_i    : start request, honoured only in StIdle
//   wipe_we_o     : write strobe for the current wipe address
//   wipe_addr_o   : entry being wiped this cycle
//   busy_o        : high while in StWipe
//   done_o        : one-cycle pulse (StDone) after the last entry
module otbn_rf_gen_ff_wipe_ctrl
    import otbn_rf_gen_ff_pkg::*;
#(
    parameter int unsigned Depth        = NGpr,
    parameter int unsigned NumHardwired = 2,
    parameter int unsigned AddrW        = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wipe_req_i,
    output logic             wipe_we_o,
    output logic [AddrW-1:0] wipe_addr_o,
    output logic             busy_o,
    output logic             done_o
);

    otbn_rf_wipe_e    state_q, state_d;
    logic [AddrW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wipe_we_o = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (wipe_req_i) begin
                    state_d = StWipe;
                    cnt_d   = AddrW'(NumHardwired);
                end
            end
            StWipe: begin
                busy_o    = 1'b1;
                wipe_we_o = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == AddrW'(Depth - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done_o  = 1'b1;
                cnt_d   = '0;
                state_d = StIdle;
            end
            // Any corrupted encoding falls back to a safe idle state.
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign wipe_addr_o = cnt_q;

endmodule

// File: rtl/otbn_rf_gen_ff.sv
// Parametrised flop-based OTBN register file with secure wipe and write-enable fault flag.
//   clk_i, rst_ni : clock, async active-low reset
//   bus (slave)   : write port, NumRdPorts combinational read ports, wipe request/data,
//                   wipe_busy_o, wipe_done_o, registered we_err_o
// Entries 0..NumHardwired-1 have no storage and read WordZeroVal, as do out-of-range addresses.
// Optional macro OTBN_RF_WE_CHECK_EN: routes the one-hot write enables through prim_buf and
// prim_onehot_check; check failures are then folded into we_err_o.
module otbn_rf_gen_ff
    import otbn_rf_gen_ff_pkg::*;
#(
    parameter int unsigned      Width        = BaseIntgWidth,
    parameter int unsigned      Depth        = NGpr,
    parameter int unsigned      NumRdPorts   = 2,
    parameter int unsigned      NumHardwired = 2,
    parameter logic [Width-1:0] WordZeroVal  = '0
) (
    input logic             clk_i,
    input logic             rst_ni,
    otbn_rf_gen_ff_if.slave bus
);

    localparam int unsigned AddrW = $clog2(Depth);

    logic                             wipe_we;
    logic [AddrW-1:0]                 wipe_addr;
    logic                             wipe_busy;
    logic                             wipe_done;
    logic                             ext_we;
    logic [Depth-1:0]                 we_onehot;
    logic [Depth-1:0]                 we_apply;
    logic [Width-1:0]                 wdata;
    logic [Width-1:0]                 rf_view [Depth];
    logic [NumRdPorts-1:0][Width-1:0] rd_data;
    logic                             we_err_d, we_err_q;

    otbn_rf_gen_ff_wipe_ctrl #(
        .Depth        (Depth),
        .NumHardwired (NumHardwired),
        .AddrW        (AddrW)
    ) u_wipe_ctrl (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .wipe_req_i  (bus.wipe_req_i),
        .wipe_we_o   (wipe_we),
        .wipe_addr_o (wipe_addr),
        .busy_o      (wipe_busy),
        .done_o      (wipe_done)
    );

    // External writes land only when idle and aimed at a real flop.
    assign ext_we = bus.wr_en_i & ~wipe_busy
                  & (32'(bus.wr_addr_i) >= NumHardwired)
                  & (32'(bus.wr_addr_i) < Depth);

    // Wipe has priority; ext_we is already blocked while busy, so this is belt and braces.
    always_comb begin
        we_onehot = '0;
        if (wipe_we) begin
            we_onehot[wipe_addr] = 1'b1;
        end else if (ext_we) begin
            we_onehot[bus.wr_addr_i] = 1'b1;
        end
    end

    assign wdata = wipe_we ? bus.wipe_data_i : bus.wr_data_i;

`ifdef OTBN_RF_WE_CHECK_EN
    logic oh_err;

    prim_buf #(
        .Width (Depth)
    ) u_we_buf (
        .in_i  (we_onehot),
        .out_o (we_apply)
    );

    prim_onehot_check #(
        .AddrWidth   (AddrW),
        .OneHotWidth (Depth),
        .AddrCheck   (1),
        .EnableCheck (1)
    ) u_we_check (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .oh_i   (we_apply),
        .addr_i (wipe_we ? wipe_addr : bus.wr_addr_i),
        .en_i   (wipe_we | ext_we),
        .err_o  (oh_err)
    );

    assign we_err_d = oh_err | (bus.wr_en_i & wipe_busy);
`else
    assign we_apply = we_onehot;
    assign we_err_d = bus.wr_en_i & wipe_busy;
`endif

    for (genvar i = 0; i < Depth; i++) begin : g_rf
        if (i < NumHardwired) begin : g_hw
            logic unused_we;
            assign unused_we  = we_apply[i];
            assign rf_view[i] = WordZeroVal;
        end else begin : g_ff
            logic [Width-1:0] q;
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    q <= WordZeroVal;
                end else if (we_apply[i]) begin
                    q <= wdata;
                end
            end
            assign rf_view[i] = q;
        end
    end

    // No write-to-read bypass: reads see the flop contents only.
    always_comb begin
        for (int p = 0; p < NumRdPorts; p++) begin
            rd_data[p] = WordZeroVal;
            if (32'(bus.rd_addr_i[p]) < Depth) begin
                rd_data[p] = rf_view[bus.rd_addr_i[p]];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_err_q <= 1'b0;
        end else begin
            we_err_q <= we_err_d;
        end
    end

    assign bus.rd_data_o   = rd_data;
    assign bus.wipe_busy_o = wipe_busy;
    assign bus.wipe_done_o = wipe_done;
    assign bus.we_err_o    = we_err_q;

endmodule

// File: tb/tb_otbn_rf_gen_ff.sv
// Self-checking bench for otbn_rf_gen_ff (default parameters).
module tb_otbn_rf_gen_ff;
    import otbn_rf_gen_ff_pkg::*;

    localparam int unsigned W  = 39;
    localparam int unsigned D  = 32;
    localparam int unsigned NR = 2;
    localparam int unsigned AW = 5;

`ifdef OTBN_RF_WE_CHECK_EN
    localparam logic ExpForcedErr = 1'b1;
`else
    localparam logic ExpForcedErr = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    otbn_rf_gen_ff_if #(.Width(W), .AddrW(AW), .NumRdPorts(NR)) bus ();

    otbn_rf_gen_ff #(
        .Width        (W),
        .Depth        (D),
        .NumRdPorts   (NR),
        .NumHardwired (2),
        .WordZeroVal  ('0)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [W-1:0]  wd;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic [W-1:0]  e0;
        logic [W-1:0]  e1;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Distinct, nonzero wipe value for busy cycle k.
    function automatic logic [W-1:0] wipe_val(input int k);
        return {7'(k + 3), 32'h0101_0101 * 32'(k + 1)};
    endfunction

    task automatic read_all_zero(input string tag);
        for (int a = 0; a < 32; a++) begin
            bus.rd_addr_i[0] = AW'(a);
            bus.rd_addr_i[1] = AW'(31 - a);
            #1;
            check({tag, "_p0"}, bus.rd_data_o[0], '0);
            check({tag, "_p1"}, bus.rd_data_o[1], '0);
        end
    endtask

    // Requests a wipe and follows it to completion; with_extras injects a busy write and a
    // second request that must be ignored.
    task automatic run_wipe(input string tag, input bit with_extras);
        int cycles;
        @(negedge clk);
        bus.wipe_req_i = 1'b1;
        @(negedge clk);
        bus.wipe_req_i = 1'b0;
        cycles = 0;
        while (bus.wipe_busy_o && cycles < 40) begin
            bus.wipe_data_i = wipe_val(cycles);
            if (cycles == 0) check({tag, "_done_low_in_busy"}, bus.wipe_done_o, 0);
            if (with_extras) begin
                case (cycles)
                    3: begin
                        bus.wr_en_i   = 1'b1;
                        bus.wr_addr_i = 5'd7;
                        bus.wr_data_i = 39'h7E_DEAD_BEEF;
                    end
                    4: begin
                        bus.wr_en_i = 1'b0;
                        check({tag, "_we_err_set"}, bus.we_err_o, 1);
                    end
                    5: begin
                        check({tag, "_we_err_one_cycle"}, bus.we_err_o, 0);
                        bus.wipe_req_i = 1'b1;
                    end
                    6: bus.wipe_req_i = 1'b0;
                    default: ;
                endcase
            end
            cycles++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, 64'(cycles), 30);
        check({tag, "_done_pulse"}, bus.wipe_done_o, 1);
        @(negedge clk);
        check({tag, "_done_once"}, bus.wipe_done_o, 0);
        check({tag, "_idle_after"}, bus.wipe_busy_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 5'd5,  39'h12_3456_789A, 5'd5,  5'd0,  39'h0,            39'h0};
        vecs[1] = '{1'b1, 5'd1,  39'h7F_FFFF_FFFF, 5'd5,  5'd0,  39'h12_3456_789A, 39'h0};
        vecs[2] = '{1'b1, 5'd31, 39'h55_5555_5555, 5'd1,  5'd5,  39'h0,            39'h12_3456_789A};
        vecs[3] = '{1'b1, 5'd0,  39'h00_0000_0011, 5'd31, 5'd1,  39'h55_5555_5555, 39'h0};
        vecs[4] = '{1'b1, 5'd2,  39'h00_0000_000A, 5'd0,  5'd31, 39'h0,            39'h55_5555_5555};
        vecs[5] = '{1'b0, 5'd5,  39'h00_0000_0001, 5'd2,  5'd5,  39'h00_0000_000A, 39'h12_3456_789A};
        vecs[6] = '{1'b1, 5'd5,  39'h2A_AAAA_AAAA, 5'd5,  5'd2,  39'h12_3456_789A, 39'h00_0000_000A};
        vecs[7] = '{1'b0, 5'd0,  39'h0,            5'd5,  5'd3,  39'h2A_AAAA_AAAA, 39'h0};

        bus.wr_en_i     = 1'b0;
        bus.wr_addr_i   = '0;
        bus.wr_data_i   = '0;
        bus.rd_addr_i   = '0;
        bus.wipe_req_i  = 1'b0;
        bus.wipe_data_i = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_busy", bus.wipe_busy_o, 0);
        check("rst_done", bus.wipe_done_o, 0);
        check("rst_we_err", bus.we_err_o, 0);
        rst_n = 1'b1;
        @(negedge clk);
        read_all_zero("rst_read");
        check("rst_busy_after", bus.wipe_busy_o, 0);

        // Directed write/read vectors; each read sees state before this cycle's write.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.wr_en_i      = vecs[i].we;
            bus.wr_addr_i    = vecs[i].wa;
            bus.wr_data_i    = vecs[i].wd;
            bus.rd_addr_i[0] = vecs[i].ra0;
            bus.rd_addr_i[1] = vecs[i].ra1;
            #1;
            check($sformatf("vec%0d_p0", i), bus.rd_data_o[0], vecs[i].e0);
            check($sformatf("vec%0d_p1", i), bus.rd_data_o[1], vecs[i].e1);
        end
        @(negedge clk);
        bus.wr_en_i = 1'b0;
        check("we_err_idle_writes", bus.we_err_o, 0);

        // Full wipe with a write during busy and an ignored second request.
        run_wipe("wipe1", 1'b1);
        check("we_err_after_wipe", bus.we_err_o, 0);
        for (int a = 0; a < 32; a++) begin
            bus.rd_addr_i[0] = AW'(a);
            bus.rd_addr_i[1] = AW'(a);
            #1;
            check($sformatf("wipe1_entry%0d", a), bus.rd_data_o[0],
                  (a < 2) ? 64'h0 : 64'(wipe_val(a - 2)));
        end

        // Reset in the middle of a wipe.
        begin
            int k;
            @(negedge clk);
            bus.wipe_req_i = 1'b1;
            @(negedge clk);
            bus.wipe_req_i = 1'b0;
            k = 0;
            while (bus.wipe_busy_o && k < 10) begin
                bus.wipe_data_i = wipe_val(k + 100);
                k++;
                @(negedge clk);
            end
            check("abort_reached_cycle10", 64'(k), 10);
            check("abort_busy_before", bus.wipe_busy_o, 1);
            rst_n = 1'b0;
            #1;
            check("abort_busy_drop", bus.wipe_busy_o, 0);
            check("abort_no_done", bus.wipe_done_o, 0);
            read_all_zero("abort_read");
            @(negedge clk);
            rst_n = 1'b1;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                check("abort_no_done_later", bus.wipe_done_o, 0);
            end
        end
        run_wipe("wipe2", 1'b0);

        // Corrupted one-hot write enable.
        @(negedge clk);
        bus.wr_en_i   = 1'b1;
        bus.wr_addr_i = 5'd3;
        bus.wr_data_i = 39'h1;
        force dut.we_onehot = 32'h0000_0208;
        @(negedge clk);
        release dut.we_onehot;
        bus.wr_en_i = 1'b0;
        check("we_err_forced", bus.we_err_o, 64'(ExpForcedErr));
        @(negedge clk);
        check("we_err_forced_clear", bus.we_err_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
